// File: rtl/load_updown_counter.sv
// load_updown_counter: up/down counter with clear, parallel load and wrap flag.
// Define COUNTER_STICKY_OVF_EN to make overflow sticky until rst or clr.
module load_updown_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [15:0]      load_val,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] count_q, count_d, load_w;
  logic ovf_q, ovf_d, wrap;
  if (WIDTH > 16) begin : g_ext
    assign load_w = {{(WIDTH-16){1'b0}}, load_val};
  end else if (WIDTH == 16) begin : g_eq
    assign load_w = load_val;
  end else begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^load_val[15:WIDTH];
    assign load_w = load_val[WIDTH-1:0];
  end
  assign wrap = en & (up ? ~|count_q : &count_q);
  always_comb begin
    count_d = clr ? '0 : load ? load_w : en ? (up ? count_q - ONE : count_q + ONE) : count_q;
`ifdef COUNTER_STICKY_OVF_EN
    ovf_d = ~clr & (ovf_q | (~load & wrap));
`else
    ovf_d = ~clr & ~load & wrap;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count    = count_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_load_updown_counter.sv
// tb_load_updown_counter: directed vectors for WIDTH=5 and WIDTH=20 counters.
module tb_load_updown_counter;
`ifdef COUNTER_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, clr, en, up, load;
  logic [15:0] load_val;
  logic [4:0]  cnt5;
  logic [19:0] cnt20;
  logic ovf5, ovf20;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  load_updown_counter #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(cnt5), .overflow(ovf5));
  load_updown_counter #(.WIDTH(20)) dut20 (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(cnt20), .overflow(ovf20));
  typedef struct {
    logic r, c, l, e, u;
    logic [15:0] lv;
    logic [4:0] cnt;
    logic op, os;
  } vec_t;
  vec_t v[29];
  task automatic tick(input logic r, c, l, e, u, input logic [15:0] lv);
    @(negedge clk);
    rst = r; clr = c; load = l; en = e; up = u; load_val = lv;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  initial begin
    //        r  c  l  e  u  lv        cnt op os
    v = '{
      '{1,0,0,0,0,16'h0000, 0,0,0},
      '{1,0,0,0,0,16'h0000, 0,0,0},
      '{0,0,0,1,0,16'h0000, 1,0,0},
      '{0,0,1,0,0,16'h001E,30,0,0},
      '{0,0,0,1,0,16'h0000,31,0,0},
      '{0,0,0,1,0,16'h0000, 0,1,1},
      '{0,0,0,1,0,16'h0000, 1,0,1},
      '{0,0,1,0,0,16'hFFE3, 3,0,1},
      '{0,0,0,1,1,16'h0000, 2,0,1},
      '{0,0,0,1,1,16'h0000, 1,0,1},
      '{0,0,0,1,1,16'h0000, 0,0,1},
      '{0,0,0,1,1,16'h0000,31,1,1},
      '{0,0,0,1,1,16'h0000,30,0,1},
      '{0,0,1,0,0,16'h000A,10,0,1},
      '{0,1,1,1,0,16'h0007, 0,0,0},
      '{1,0,1,0,0,16'h0007, 0,0,0},
      '{0,0,1,0,0,16'h000C,12,0,0},
      '{0,0,0,0,0,16'h0000,12,0,0},
      '{0,0,0,0,1,16'h0000,12,0,0},
      '{0,0,0,0,0,16'h0000,12,0,0},
      '{0,0,0,0,1,16'h0000,12,0,0},
      '{0,0,0,0,0,16'h0000,12,0,0},
      '{0,0,1,1,0,16'h0005, 5,0,0},
      '{0,0,0,1,1,16'h0000, 4,0,0},
      '{0,1,0,0,0,16'h0000, 0,0,0},
      '{0,0,0,1,1,16'h0000,31,1,1},
      '{0,0,0,0,0,16'h0000,31,0,1},
      '{0,1,0,0,0,16'h0000, 0,0,0},
      '{1,0,0,1,0,16'h0000, 0,0,0}
    };
    rst = 1; clr = 0; load = 0; en = 0; up = 0; load_val = '0;
    for (int i = 0; i < 29; i++) begin
      tick(v[i].r, v[i].c, v[i].l, v[i].e, v[i].u, v[i].lv);
      check("vec_count", i, 32'(cnt5), 32'(v[i].cnt));
      check("vec_ovf", i, 32'(ovf5), 32'(STICKY ? v[i].os : v[i].op));
    end
    // free run from reset over two full wraps of the 5-bit counter
    tick(1, 0, 0, 0, 0, 16'h0);
    tick(1, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < 66; k++) begin
      logic [4:0] ec;
      logic eo;
      tick(0, 0, 0, 1, 0, 16'h0);
      ec = 5'((k + 1) % 32);
      eo = STICKY ? (k >= 31) : (ec == 5'd0);
      check("run_count", k, 32'(cnt5), 32'(ec));
      check("run_ovf", k, 32'(ovf5), 32'(eo));
    end
    // WIDTH=20: zero-extended load, carry past bit 15, down-wrap from zero
    tick(1, 0, 0, 0, 0, 16'h0);
    check("w20_rst", 0, 32'(cnt20), 32'h0);
    check("w20_rst_ovf", 0, 32'(ovf20), 32'h0);
    tick(0, 0, 1, 0, 0, 16'hFFFF);
    check("w20_load", 0, 32'(cnt20), 32'h0FFFF);
    tick(0, 0, 0, 1, 0, 16'h0);
    check("w20_carry", 0, 32'(cnt20), 32'h10000);
    check("w20_carry_ovf", 0, 32'(ovf20), 32'h0);
    tick(0, 1, 0, 0, 0, 16'h0);
    check("w20_clr", 0, 32'(cnt20), 32'h0);
    tick(0, 0, 0, 1, 1, 16'h0);
    check("w20_wrap", 0, 32'(cnt20), 32'hFFFFF);
    check("w20_wrap_ovf", 0, 32'(ovf20), 32'h1);
    tick(0, 0, 0, 1, 1, 16'h0);
    check("w20_after", 0, 32'(cnt20), 32'hFFFFE);
    check("w20_after_ovf", 0, 32'(ovf20), 32'(STICKY));
    tick(0, 1, 0, 0, 0, 16'h0);
    check("w20_clr_ovf", 0, 32'(ovf20), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_updown_counter.md
Name: load_updown_counter

Overview:
- Parameterised synchronous binary counter with enable, clear, direction and parallel load.
- Produces a wrap (overflow/underflow) indication.
- Used as a free-running time base in the seven-segment display controller: the top 3 count bits select the active digit, with clr=0, en=1, up=0, load=0, load_val=0.
- Ports are connected positionally in the order listed under Ports.

Parameters:
- WIDTH, 20, counter width in bits; legal range 2..32.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear to zero.
- en  in  1  count enable.
- up  in  1  direction: 0 = count up, 1 = count down.
- load  in  1  synchronous parallel load.
- load_val  in  16  load value.
- count  out  WIDTH  current count, registered.
- overflow  out  1  wrap indication, registered.

Behaviour:
- Reset: rst=1 at a rising edge sets count=0 and overflow=0. rst overrides every other input. Reset mid-count takes effect on that edge.
- Control priority at each rising edge: rst > clr > load > en.
- clr=1: count<=0, overflow<=0.
- load=1:
  - count<=load_val resized to WIDTH: zero-extended if WIDTH>16, low WIDTH bits kept if WIDTH<16.
  - overflow<=0.
  - Load takes precedence over en in the same cycle.
- en=1 with up=0: count<=count+1, modulo 2^WIDTH.
- en=1 with up=1: count<=count-1, modulo 2^WIDTH.
- Wrap conditions:
  - Counting up: count = all-ones wraps to 0.
  - Counting down: count = 0 wraps to all-ones.
  - On a wrap, overflow<=1 in the same edge that count wraps, so overflow=1 coincides with the wrapped value.
- overflow is a one-cycle pulse: it is 0 on every edge that does not wrap, including en=0 hold cycles.
- en=0 with no clr/load/rst: count holds, overflow<=0.
- Latency: every input affects outputs one clock after sampling. No combinational input-to-output paths.
- count and overflow change only on rising clk edges.
- No X propagation from load_val when load=0.

Optional Feature:
- Macro COUNTER_STICKY_OVF_EN.
- Defined:
  - overflow becomes a sticky flag: set on any wrap, held until rst=1 or clr=1.
  - load does not clear it.
- Undefined: overflow is the single-cycle pulse described above.

Test Plan:
- WIDTH=5, rst=1 for 2 cycles then en=1, up=0 -> count 0,1,2,…,31; at the edge where 31→0, overflow=1 for exactly one cycle. Repeats every 32 cycles.
- WIDTH=5, load=1, load_val=16'h001E, then en=1 up=0 -> count=30, 31, 0 with overflow=1 at 0, then 1 with overflow=0.
- WIDTH=5, load_val=16'hFFE3, load=1 -> count=3 (truncation); then up=1, en=1 -> 2,1,0,31 with overflow=1 at 31.
- WIDTH=5, count=10, en=1, clr=1 and load=1 (load_val=7) same cycle -> count=0. Next cycle rst=1 together with load=1 -> count=0, overflow=0.
- WIDTH=5, count=12, en=0 for 5 cycles -> count stays 12, overflow=0. Also run WIDTH=20 for 2^20 cycles -> single overflow pulse at wrap.
- With COUNTER_STICKY_OVF_EN, WIDTH=5, free-run up past wrap -> overflow stays 1 through later counts and a load. clr=1 -> overflow=0.
